// File: rtl/lfsr_checker_if.sv
// Bus between a noise-word source and the LFSR sequence checker.
// din_valid qualifies din with no ready: the checker accepts every word presented while din_valid is high.
interface lfsr_checker_if #(
    parameter int CNT_W = 16
) ();
    logic [11:0]      din;
    logic             din_valid;
    logic             clear_count;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic [11:0]      expected;
    logic [1:0]       state_dbg;

    modport master (
        output din, din_valid, clear_count,
        input  locked, err_pulse, err_count, expected, state_dbg
    );

    modport slave (
        input  din, din_valid, clear_count,
        output locked, err_pulse, err_count, expected, state_dbg
    );
endinterface

// File: rtl/lfsr_checker.sv
// Locks onto a 14-bit XNOR noise LFSR from three consecutive 12-bit words,
// then predicts each following word and counts mismatches.
module lfsr_checker #(
    parameter int LOSS_THRESH = 4,
    parameter int CNT_W       = 16
) (
    input logic         clk,
    input logic         rst,
    lfsr_checker_if.slave bus
);
    localparam int MW = $clog2(LOSS_THRESH + 1);

    typedef enum logic [1:0] {SEARCH, SEED1, SEED2, LOCKED} state_t;

    function automatic logic [13:0] step(input logic [13:0] s);
        return {s[12:0], ~(s[13] ^ s[12] ^ s[11] ^ s[1])};
    endfunction

    state_t           state;
    logic [13:0]      s_q;
    logic [11:0]      w0;
    logic [11:0]      w1;
    logic [MW-1:0]    miss_q;
    logic             locked_q;
    logic             err_pulse_q;
    logic [CNT_W-1:0] cnt_q;

    logic [13:0]      s_next;
    logic [13:0]      s0;
    logic [MW-1:0]    miss_inc;

    assign s_next   = step(s_q);
    // The third seed word supplies the two state bits the first word lacks.
    assign s0       = {w0, bus.din[1:0]};
    assign miss_inc = miss_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SEARCH;
            s_q         <= '0;
            w0          <= '0;
            w1          <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            err_pulse_q <= 1'b0;
            if (bus.din_valid) begin
                case (state)
                    SEARCH: begin
                        w0    <= bus.din;
                        state <= SEED1;
                    end
                    SEED1: begin
                        if (bus.din[11:1] == w0[10:0]) begin
                            w1    <= bus.din;
                            state <= SEED2;
                        end else begin
                            w0 <= bus.din;
                        end
                    end
                    SEED2: begin
                        // All-ones is the XNOR lock-up state and can never be a real seed.
                        if (bus.din[11:1] == w1[10:0] && s0 != '1) begin
                            s_q      <= step(step(s0));
                            miss_q   <= '0;
                            locked_q <= 1'b1;
                            state    <= LOCKED;
                        end else begin
                            w0    <= bus.din;
                            state <= SEED1;
                        end
                    end
                    LOCKED: begin
                        s_q <= s_next;
                        if (bus.din != s_next[13:2]) begin
                            err_pulse_q <= 1'b1;
                            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                            if (miss_inc == MW'(LOSS_THRESH)) begin
                                miss_q   <= '0;
                                locked_q <= 1'b0;
                                state    <= SEARCH;
                            end else begin
                                miss_q <= miss_inc;
                            end
                        end else begin
                            miss_q <= '0;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
            if (bus.clear_count) cnt_q <= '0;
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_count = cnt_q;
    assign bus.expected  = s_next[13:2];
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_lfsr_checker.sv
// Randomized scoreboard bench for lfsr_checker against a queue-based behavioural model.
module tb_lfsr_checker;
    localparam int LOSS = 4;
    localparam int EW   = 36;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lfsr_checker_if #(.CNT_W(16)) bus1 ();
    lfsr_checker_if #(.CNT_W(4))  bus2 ();

    assign bus2.din         = bus1.din;
    assign bus2.din_valid   = bus1.din_valid;
    assign bus2.clear_count = bus1.clear_count;

    lfsr_checker #(.LOSS_THRESH(LOSS), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus1));
    lfsr_checker #(.LOSS_THRESH(LOSS), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus2));

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    // Behavioural model: pre-lock words collect in a queue of consistent candidates.
    int unsigned m_cnt, m_cnt4;
    int          m_miss;
    bit          m_locked, m_pulse;
    logic [13:0] m_s;
    logic [11:0] hist[$];
    logic [13:0] g;

    function automatic logic [13:0] gstep(input logic [13:0] s);
        return {s[12:0], ~(s[13] ^ s[12] ^ s[11] ^ s[1])};
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_cnt4 = 0; m_miss = 0; m_locked = 0; m_pulse = 0; m_s = '0;
        hist.delete();
    endtask

    task automatic model(input logic [11:0] d, input bit v, input bit clr);
        logic [11:0] last;
        logic [13:0] s0;
        m_pulse = 0;
        if (v) begin
            if (m_locked) begin
                if (d != m_s[13:2]) begin
                    m_pulse = 1;
                    if (m_cnt < 65535) m_cnt++;
                    if (m_cnt4 < 15) m_cnt4++;
                    m_miss++;
                    if (m_miss == LOSS) begin
                        m_locked = 0;
                        m_miss = 0;
                        hist.delete();
                    end
                end else begin
                    m_miss = 0;
                end
                m_s = gstep(m_s);
            end else begin
                if (hist.size() > 0) begin
                    last = hist[hist.size()-1];
                    if (d[11:1] != last[10:0]) hist.delete();
                end
                hist.push_back(d);
                if (hist.size() == 3) begin
                    s0 = {hist[0], d[1:0]};
                    hist.delete();
                    if (s0 == 14'h3FFF) begin
                        hist.push_back(d);
                    end else begin
                        m_s = gstep(gstep(gstep(s0)));
                        m_locked = 1;
                        m_miss = 0;
                    end
                end
            end
        end
        if (clr) begin
            m_cnt = 0;
            m_cnt4 = 0;
        end
    endtask

    function automatic logic [EW-1:0] pack_exp();
        logic [1:0] st;
        st = m_locked ? 2'd3 : 2'(hist.size());
        return {st, m_locked, m_pulse, m_cnt[15:0], m_cnt4[3:0], m_s[13:2]};
    endfunction

    task automatic drive(input logic [11:0] d, input bit v, input bit clr);
        bus1.din         = d;
        bus1.din_valid   = v;
        bus1.clear_count = clr;
        @(posedge clk);
        model(d, v, clr);
        exp_q.push_back(pack_exp());
        #1;
        bus1.din_valid   = 1'b0;
        bus1.clear_count = 1'b0;
    endtask

    task automatic send(input logic [11:0] mask, input bit clr = 1'b0);
        drive(g[13:2] ^ mask, 1'b1, clr);
        g = gstep(g);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_locked", bus1.locked, 0);
        check("rst_err_pulse", bus1.err_pulse, 0);
        check("rst_err_count", bus1.err_count, 0);
        check("rst_expected", bus1.expected, 0);
        check("rst_state", bus1.state_dbg, 0);
        check("rst_err_count4", bus2.err_count, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every cycle the DUT presents a full set of outputs.
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("state", bus1.state_dbg, e[35:34]);
                check("locked", bus1.locked, e[33]);
                check("err_pulse", bus1.err_pulse, e[32]);
                check("err_count", bus1.err_count, e[31:16]);
                check("err_count_sat4", bus2.err_count, e[15:12]);
                if (e[33]) check("expected", bus1.expected, e[11:0]);
            end
        end
    end

    initial begin
        bus1.din = '0;
        bus1.din_valid = 1'b0;
        bus1.clear_count = 1'b0;
        model_reset();
        do_reset();

        // Clean stream from the generator's zero state, through a period wrap.
        g = '0;
        for (int i = 0; i < 20000; i++) send(12'h000);

        // Single bit flip.
        send(12'h001);
        for (int i = 0; i < 5; i++) send(12'h000);

        // Four consecutive corrupted words drop lock, clean words relock.
        for (int i = 0; i < 4; i++) send(12'($urandom_range(1, 4095)));
        for (int i = 0; i < 10; i++) send(12'h000);

        // Sparse errors that never drop lock, driving the narrow counter into saturation.
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 3; i++) send(12'($urandom_range(1, 4095)));
            send(12'h000);
        end

        // Random valid gaps and occasional clears on a clean stream.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 1) == 1) send(12'h000, ($urandom_range(0, 49) == 0));
            else drive(12'($urandom), 1'b0, ($urandom_range(0, 49) == 0));
        end

        // Inconsistent seed words keep the checker in SEED1.
        do_reset();
        drive(12'h000, 1'b1, 1'b0);
        drive(12'hABC, 1'b1, 1'b0);
        drive(12'h000, 1'b0, 1'b0);
        g = 14'($urandom_range(0, 16382));
        for (int i = 0; i < 30; i++) send(12'h000);

        // Five isolated errors, then an asynchronous reset mid-lock.
        for (int i = 0; i < 5; i++) begin
            send(12'($urandom_range(1, 4095)));
            send(12'h000);
        end
        do_reset();
        for (int i = 0; i < 10; i++) send(12'h000);

        // Clear coinciding with a mismatch: counter zeroed, pulse still raised.
        send(12'h010);
        send(12'h000);
        send(12'h200);
        send(12'h400, 1'b1);
        for (int i = 0; i < 5; i++) send(12'h000);

        // A stream stuck in the lock-up state must never lock.
        g = 14'h3FFF;
        for (int i = 0; i < 10; i++) send(12'h000);
        g = 14'($urandom_range(0, 16382));
        for (int i = 0; i < 20; i++) send(12'h000);

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 SHALL have parameter LOSS_THRESH, default 4: consecutive mismatched words that drop lock.
REQ-002 SHALL have parameter CNT_W, default 16: error counter width.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port din, input, 12 bits: received noise word, which is bits [13:2] of the 14-bit noise LFSR state.
REQ-006 SHALL have port din_valid, input, 1 bit: din holds the next consecutive generator word; ignored when low.
REQ-007 SHALL have port clear_count, input, 1 bit: synchronous clear of err_count.
REQ-008 SHALL have port locked, output, 1 bit: checker is tracking the sequence.
REQ-009 SHALL have port err_pulse, output, 1 bit: one-cycle flag marking a mismatched word.
REQ-010 SHALL have port err_count, output, CNT_W bits: saturating mismatch count.
REQ-011 SHALL have port expected, output, 12 bits: predicted next word, meaningful only while locked.

Function
REQ-012 SHALL model the generator step S' = {S[12:0], ~(S[13]^S[12]^S[11]^S[1])} on a 14-bit local state S.
- This sequence has period 16383.
- The all-ones state is the lock-up state.
REQ-013 SHALL implement the FSM states SEARCH, SEED1, SEED2, LOCKED, and SHALL advance only on cycles with din_valid=1.
REQ-014 In SEARCH, a valid word SHALL be stored as w0, and the FSM SHALL go to SEED1.
REQ-015 In SEED1, a valid word w1 with w1[11:1]==w0[10:0] SHALL be stored, and the FSM SHALL go to SEED2.
- Otherwise w1 SHALL replace w0, and the FSM SHALL stay in SEED1.
REQ-016 In SEED2, a valid word w2 with w2[11:1]==w1[10:0] SHALL reconstruct S0={w0, w2[1:0]}.
- If S0 is all-ones, w2 SHALL become w0 and the FSM SHALL go to SEED1.
- Otherwise S SHALL load step(step(S0)), and the FSM SHALL go to LOCKED.
REQ-017 In SEED2, a failed consistency check SHALL make w2 the new w0 and return the FSM to SEED1.
REQ-018 locked SHALL be registered and SHALL rise on the clock edge that enters LOCKED, i.e. visible the cycle after w2 is accepted.
REQ-019 In LOCKED, expected SHALL equal step(S)[13:2] continuously.
- On each valid word, din SHALL be compared with expected.
- S SHALL advance one step whether or not the word matched; there is no reseeding from data.
REQ-020 On a LOCKED mismatch, err_pulse SHALL be high for exactly the next cycle.
- err_count SHALL increment, saturating at all-ones.
- The consecutive-miss counter SHALL increment.
REQ-021 On a LOCKED match, the consecutive-miss counter SHALL clear to 0.
REQ-022 When the consecutive-miss counter reaches LOSS_THRESH, the FSM SHALL go to SEARCH, and locked SHALL fall on that same edge.
- The triggering mismatch SHALL still be counted and pulsed.
REQ-023 err_pulse and err_count SHALL never change outside LOCKED.
REQ-024 clear_count SHALL zero err_count on the next edge.
- It SHALL take priority over a same-cycle mismatch; that mismatch is not counted but still pulses.
REQ-025 Gaps in din_valid SHALL freeze all state, with err_pulse low.

Reset
REQ-026 rst SHALL asynchronously force the following, at any time including mid-seed or mid-lock:
- FSM=SEARCH, S=0, w0/w1=0, miss counter=0.
- locked=0, err_pulse=0, err_count=0, expected=0.
REQ-027 After rst deasserts, operation SHALL resume from the first valid word with no additional warm-up.

Verification
REQ-028 SHALL cover: reference generator from its zero reset state, one word per cycle -> locked=1 one cycle after the 3rd word; err_count=0 after 20000 words, including a period wrap.
REQ-029 SHALL cover: locked stream with one word bit-flipped (din ^= 12'h001) -> single err_pulse, err_count=1, locked stays 1, next word matches.
REQ-030 SHALL cover: 4 consecutive corrupted words -> err_count=4, locked falls after the 4th; clean stream relocks after 3 words.
REQ-031 SHALL cover: inconsistent seed words 12'h000, 12'hABC -> stays in SEED1 with w0=12'hABC; err_count stays 0.
REQ-032 SHALL cover: din_valid toggled 1/0 randomly on a clean stream -> no errors, lock held; err_count preset to 16'hFFFF plus a mismatch -> stays 16'hFFFF.
REQ-033 SHALL cover: rst pulse mid-LOCKED with err_count=5 -> all outputs 0 immediately; clear_count with a same-cycle mismatch -> err_count=0 and err_pulse=1.
